id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus operand forwarding and load-use hazard detect for the RV32I core.
//  Captures decoded operands from ID and produces ALUop1/ALUop2/ALUctrl for the ALU directly downstream.
//  Bypasses EX/MEM and MEM/WB results and inserts bubbles on load-use hazards or branch flush.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width
//  REG_AW      5   register index width
// PORTS
//  clk            in   1      rising-edge clock, sole clock
//  rst_n          in   1      reset, synchronous, active-low
//  id_valid       in   1      ID holds a real instruction
//  id_rs1,id_rs2  in   5      source register indices
//  id_rd          in   5      destination index
//  id_rd1,id_rd2  in   32     regfile read data
//  id_imm,id_pc   in   32     immediate, instruction PC
//  id_srca_pc     in   1      1: op1=PC, 0: op1=rs1
//  id_srcb_imm    in   1      1: op2=imm, 0: op2=rs2
//  id_aluctrl     in   4      ALU opcode (0000 ADD .. 1011 PASSB)
//  id_regwrite    in   1      writes rd
//  id_memread     in   1      is a load
//  flush          in   1      taken branch/jump: kill ID instruction
//  exmem_regwrite in   1      EX/MEM writer valid
//  exmem_rd       in   5      EX/MEM destination
//  exmem_result   in   32     EX/MEM ALU result
//  memwb_regwrite in   1      MEM/WB writer valid
//  memwb_rd       in   5      MEM/WB destination
//  memwb_result   in   32     MEM/WB writeback data
//  stall          out  1      hold PC and IF/ID (combinational)
//  ex_valid       out  1      EX holds a real instruction
//  ALUop1,ALUop2  out  32     forwarded/selected ALU operands
//  ALUctrl        out  8      {4'b0, opcode}
//  ex_rd          out  5      destination passed to EX/MEM
//  ex_regwrite    out  1      gated by ex_valid
//  ex_memread     out  1      gated by ex_valid
//  ex_store_data  out  32     forwarded rs2 value (for stores)
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): every register 0 -> ex_valid=0, ALUop1=ALUop2=0, ALUctrl=0, ex_rd=0,
//    ex_regwrite=ex_memread=0, ex_store_data=0; stall=0 because ex_valid=0. Reset mid-stall drops the bubble.
//  - Hazard: ex_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & id_valid.
//    Both rs fields always compared; false stalls on unused fields are accepted.
//  - stall = hazard & ~flush.
//  - Edge priority: reset > flush > stall > capture. Flush and stall each load a bubble
//    (all regs 0, ex_valid=0). Capture loads id_* with ex_valid=id_valid. Latency: ID to ALU is 1 cycle.
//  - Capture-time bypass: if memwb_regwrite & memwb_rd!=0 & memwb_rd==id_rsN, latch memwb_result
//    instead of id_rdN. This covers the writeback-same-cycle-as-read case.
//  - EX-time forwarding (combinational) for each rsN:
//    exmem match (regwrite, rd!=0, rd==rsN) > memwb match > latched value. x0 never forwarded.
//  - ALUop1 = srca_pc ? pc : fwd_rs1. ALUop2 = srcb_imm ? imm : fwd_rs2. ex_store_data = fwd_rs2 always.
//  - Widths: no arithmetic here. Indices compare at REG_AW bits. ALUctrl[7:4] tied 0.
// CONFIGURATION
//  EX_PERF_CNT_EN defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
//    - stall_cnt +1 each cycle with stall=1; flush_cnt +1 each cycle with flush=1.
//    - Counters saturate at 32'hFFFF_FFFF and clear on reset.
//  EX_PERF_CNT_EN undefined: ports and counters absent, otherwise identical.
// STRUCTURE
//  ex_pkg: alu_op_t enum (ALU_ADD=4'h0..ALU_PASSB=4'hB), fwd_sel_t {FWD_REG, FWD_MEMWB, FWD_EXMEM},
//    id_ex_t packed struct of the latched fields.
//  Sub-module fwd_unit: pure combinational; takes rs, writer ports, latched value; returns fwd_sel_t
//    and data. Instantiated twice (rs1, rs2).
// TESTING
//  1 Reset: hold rst_n=0 two edges with id_valid=1 -> ex_valid=0, ALUop1=ALUop2=0, stall=0.
//  2 EX/MEM fwd: latched x5=7, exmem_regwrite=1, exmem_rd=5, exmem_result=42, memwb x5=99, rs1=5
//    -> ALUop1=42. Repeat with exmem_rd=0 and rs1=0 -> ALUop1=latched 0.
//  3 Load-use: EX holds lw x6, ID add rs2=6 -> stall=1 one cycle, next ex_valid=0, ALUctrl=0.
//    The following cycle captures the add with stall=0.
//  4 Flush during hazard: load-use plus flush=1 -> stall=0, bubble loaded, ID instruction never appears.
//  5 Capture bypass: memwb_rd=3, memwb_result=0x1234, id_rs1=3, id_rd1=0
//    -> after edge ALUop1=0x1234 with no other writer.
//  6 EX_PERF_CNT_EN: 3 stalls and 2 flushes -> stall_cnt=3, flush_cnt=2.
//    Preload 32'hFFFF_FFFF, stall -> counter stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types for the ID/EX stage: ALU opcodes, forwarding selects and the latched ID/EX record.
package ex_pkg;

  localparam int EX_DW = 32;
  localparam int EX_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_SLL   = 4'h2,
    ALU_SLT   = 4'h3,
    ALU_SLTU  = 4'h4,
    ALU_XOR   = 4'h5,
    ALU_SRL   = 4'h6,
    ALU_SRA   = 4'h7,
    ALU_OR    = 4'h8,
    ALU_AND   = 4'h9,
    ALU_PASSA = 4'hA,
    ALU_PASSB = 4'hB
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic             valid;
    logic [EX_AW-1:0] rs1;
    logic [EX_AW-1:0] rs2;
    logic [EX_AW-1:0] rd;
    logic [EX_DW-1:0] rv1;
    logic [EX_DW-1:0] rv2;
    logic [EX_DW-1:0] imm;
    logic [EX_DW-1:0] pc;
    logic             srca_pc;
    logic             srcb_imm;
    alu_op_t          aluctrl;
    logic             regwrite;
    logic             memread;
  } id_ex_t;

  // A writer only counts when it is enabled and not targeting x0.
  function automatic logic rd_match(input logic we, input logic [EX_AW-1:0] rd,
                                    input logic [EX_AW-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Combinational operand bypass for one source register: EX/MEM beats MEM/WB beats latched value.
module fwd_unit
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH = EX_DW,
  parameter int REG_AW     = EX_AW
) (
  input  logic [REG_AW-1:0]     rs,
  input  logic                  exmem_regwrite,
  input  logic [REG_AW-1:0]     exmem_rd,
  input  logic [DATA_WIDTH-1:0] exmem_result,
  input  logic                  memwb_regwrite,
  input  logic [REG_AW-1:0]     memwb_rd,
  input  logic [DATA_WIDTH-1:0] memwb_result,
  input  logic [DATA_WIDTH-1:0] latched,
  output fwd_sel_t              sel,
  output logic [DATA_WIDTH-1:0] data
);

  always_comb begin
    sel  = FWD_REG;
    data = latched;
    if (rd_match(exmem_regwrite, exmem_rd, rs)) begin
      sel  = FWD_EXMEM;
      data = exmem_result;
    end else if (rd_match(memwb_regwrite, memwb_rd, rs)) begin
      sel  = FWD_MEMWB;
      data = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and operand forwarding.
// Optional EX_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module id_ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH = EX_DW,
  parameter int REG_AW     = EX_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_AW-1:0]     id_rs1,
  input  logic [REG_AW-1:0]     id_rs2,
  input  logic [REG_AW-1:0]     id_rd,
  input  logic [DATA_WIDTH-1:0] id_rd1,
  input  logic [DATA_WIDTH-1:0] id_rd2,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic                  id_srca_pc,
  input  logic                  id_srcb_imm,
  input  logic [3:0]            id_aluctrl,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  flush,
  input  logic                  exmem_regwrite,
  input  logic [REG_AW-1:0]     exmem_rd,
  input  logic [DATA_WIDTH-1:0] exmem_result,
  input  logic                  memwb_regwrite,
  input  logic [REG_AW-1:0]     memwb_rd,
  input  logic [DATA_WIDTH-1:0] memwb_result,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ALUop1,
  output logic [DATA_WIDTH-1:0] ALUop2,
  output logic [7:0]            ALUctrl,
  output logic [REG_AW-1:0]     ex_rd,
  output logic                  ex_regwrite,
  output logic                  ex_memread,
  output logic [DATA_WIDTH-1:0] ex_store_data
`ifdef EX_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  id_ex_t                  ex_q;
  id_ex_t                  cap;
  logic                    hazard;
  logic [DATA_WIDTH-1:0]   fwd1_data;
  logic [DATA_WIDTH-1:0]   fwd2_data;
  fwd_sel_t                fwd1_sel;
  fwd_sel_t                fwd2_sel;
  logic                    fwd_sel_unused;

  // Both rs fields are compared regardless of use; occasional false stalls are accepted.
  assign hazard = ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
                  ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2)) && id_valid;
  assign stall  = hazard && !flush;

  // A register being written back this cycle is read stale from the regfile, so take it from MEM/WB.
  always_comb begin
    cap          = '0;
    cap.valid    = id_valid;
    cap.rs1      = id_rs1;
    cap.rs2      = id_rs2;
    cap.rd       = id_rd;
    cap.rv1      = rd_match(memwb_regwrite, memwb_rd, id_rs1) ? memwb_result : id_rd1;
    cap.rv2      = rd_match(memwb_regwrite, memwb_rd, id_rs2) ? memwb_result : id_rd2;
    cap.imm      = id_imm;
    cap.pc       = id_pc;
    cap.srca_pc  = id_srca_pc;
    cap.srcb_imm = id_srcb_imm;
    cap.aluctrl  = alu_op_t'(id_aluctrl);
    cap.regwrite = id_regwrite;
    cap.memread  = id_memread;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      ex_q <= '0;
    else if (flush || stall)
      ex_q <= '0;
    else
      ex_q <= cap;
  end

  fwd_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs             (ex_q.rs1),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .latched        (ex_q.rv1),
    .sel            (fwd1_sel),
    .data           (fwd1_data)
  );

  fwd_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs             (ex_q.rs2),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .latched        (ex_q.rv2),
    .sel            (fwd2_sel),
    .data           (fwd2_data)
  );

  // Select codes are only for waveform debug; the datapath uses the muxed data.
  assign fwd_sel_unused = ^{fwd1_sel, fwd2_sel};

  assign ex_valid      = ex_q.valid;
  assign ALUop1        = ex_q.srca_pc  ? ex_q.pc  : fwd1_data;
  assign ALUop2        = ex_q.srcb_imm ? ex_q.imm : fwd2_data;
  assign ALUctrl       = {4'b0000, ex_q.aluctrl};
  assign ex_rd         = ex_q.rd;
  assign ex_regwrite   = ex_q.valid && ex_q.regwrite;
  assign ex_memread    = ex_q.valid && ex_q.memread;
  assign ex_store_data = fwd2_data;

`ifdef EX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && (flush_cnt != 32'hFFFF_FFFF))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; perf-counter checks build only with EX_PERF_CNT_EN.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rd1, id_rd2, id_imm, id_pc;
  logic        id_srca_pc, id_srcb_imm;
  logic [3:0]  id_aluctrl;
  logic        id_regwrite, id_memread, flush;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        stall, ex_valid;
  logic [31:0] ALUop1, ALUop2, ex_store_data;
  logic [7:0]  ALUctrl;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread;
`ifdef EX_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc(id_pc),
    .id_srca_pc(id_srca_pc), .id_srcb_imm(id_srcb_imm), .id_aluctrl(id_aluctrl),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall), .ex_valid(ex_valid), .ALUop1(ALUop1), .ALUop2(ALUop2),
    .ALUctrl(ALUctrl), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_store_data(ex_store_data)
`ifdef EX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_pc = 0;
    id_srca_pc = 0; id_srcb_imm = 0; id_aluctrl = 0;
    id_regwrite = 0; id_memread = 0; flush = 0;
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Places "lw x6" into EX and leaves ID idle.
  task automatic load_lw_x6();
    idle_inputs();
    id_valid = 1; id_rs1 = 5'd2; id_rd = 5'd6; id_memread = 1; id_regwrite = 1;
    id_srcb_imm = 1; id_imm = 32'd8;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    id_valid = 1; id_rs1 = 5'd1; id_rd1 = 32'hAAAA; id_aluctrl = 4'h3; id_regwrite = 1;
    step(); step();
    total++; if (ex_valid !== 1'b0) $display("[TB] FAIL reset_ex_valid: got %b want 0", ex_valid); else passed++;
    total++; if (ALUop1 !== 32'd0) $display("[TB] FAIL reset_op1: got %h want 0", ALUop1); else passed++;
    total++; if (ALUop2 !== 32'd0) $display("[TB] FAIL reset_op2: got %h want 0", ALUop2); else passed++;
    total++; if (stall !== 1'b0) $display("[TB] FAIL reset_stall: got %b want 0", stall); else passed++;
    total++; if (ALUctrl !== 8'h00) $display("[TB] FAIL reset_aluctrl: got %h want 00", ALUctrl); else passed++;
    total++; if (ex_regwrite !== 1'b0) $display("[TB] FAIL reset_regwrite: got %b want 0", ex_regwrite); else passed++;
    rst_n = 1;
    idle_inputs();
  endtask

  task automatic test_exmem_fwd();
    idle_inputs();
    id_valid = 1; id_rs1 = 5'd5; id_rd = 5'd1; id_rd1 = 32'd7;
    id_srcb_imm = 1; id_imm = 32'd100; id_regwrite = 1;
    step();
    idle_inputs();
    exmem_regwrite = 1; exmem_rd = 5'd5; exmem_result = 32'd42;
    memwb_regwrite = 1; memwb_rd = 5'd5; memwb_result = 32'd99;
    #1;
    total++; if (ALUop1 !== 32'd42) $display("[TB] FAIL exmem_priority: got %0d want 42", ALUop1); else passed++;
    total++; if (ALUop2 !== 32'd100) $display("[TB] FAIL imm_select: got %0d want 100", ALUop2); else passed++;
    exmem_regwrite = 0; #1;
    total++; if (ALUop1 !== 32'd99) $display("[TB] FAIL memwb_fwd: got %0d want 99", ALUop1); else passed++;
    memwb_regwrite = 0; #1;
    total++; if (ALUop1 !== 32'd7) $display("[TB] FAIL latched_op1: got %0d want 7", ALUop1); else passed++;

    idle_inputs();
    id_valid = 1; id_rs1 = 5'd0; id_rd1 = 32'd0; id_rs2 = 5'd0; id_rd2 = 32'd0;
    step();
    idle_inputs();
    exmem_regwrite = 1; exmem_rd = 5'd0; exmem_result = 32'd42;
    memwb_regwrite = 1; memwb_rd = 5'd0; memwb_result = 32'd99;
    #1;
    total++; if (ALUop1 !== 32'd0) $display("[TB] FAIL x0_op1: got %0d want 0", ALUop1); else passed++;
    total++; if (ALUop2 !== 32'd0) $display("[TB] FAIL x0_op2: got %0d want 0", ALUop2); else passed++;

    idle_inputs();
    id_valid = 1; id_rs1 = 5'd5; id_rd1 = 32'd3; id_srca_pc = 1; id_pc = 32'h1000;
    id_rs2 = 5'd8; id_rd2 = 32'd11; id_srcb_imm = 1; id_imm = 32'd4; id_aluctrl = 4'hB;
    step();
    idle_inputs();
    exmem_regwrite = 1; exmem_rd = 5'd8; exmem_result = 32'd55;
    #1;
    total++; if (ALUop2 !== 32'd4) $display("[TB] FAIL imm_over_fwd: got %0d want 4", ALUop2); else passed++;
    total++; if (ex_store_data !== 32'd55) $display("[TB] FAIL store_fwd: got %0d want 55", ex_store_data); else passed++;
    total++; if (ALUctrl !== 8'h0B) $display("[TB] FAIL aluctrl_passb: got %h want 0b", ALUctrl); else passed++;
    exmem_rd = 5'd5; #1;
    total++; if (ALUop1 !== 32'h1000) $display("[TB] FAIL pc_over_fwd: got %h want 1000", ALUop1); else passed++;
    total++; if (ex_store_data !== 32'd11) $display("[TB] FAIL store_latched: got %0d want 11", ex_store_data); else passed++;
    idle_inputs();
  endtask

  task automatic test_load_use();
    load_lw_x6();
    id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd6; id_rd = 5'd7;
    id_rd1 = 32'd10; id_rd2 = 32'd20; id_regwrite = 1; id_aluctrl = 4'h0;
    #1;
    total++; if (stall !== 1'b1) $display("[TB] FAIL loaduse_stall: got %b want 1", stall); else passed++;
    total++; if (ex_memread !== 1'b1) $display("[TB] FAIL lw_memread: got %b want 1", ex_memread); else passed++;
    step();
    total++; if (ex_valid !== 1'b0) $display("[TB] FAIL bubble_valid: got %b want 0", ex_valid); else passed++;
    total++; if (ALUctrl !== 8'h00) $display("[TB] FAIL bubble_aluctrl: got %h want 00", ALUctrl); else passed++;
    total++; if (ex_rd !== 5'd0) $display("[TB] FAIL bubble_rd: got %0d want 0", ex_rd); else passed++;
    total++; if (stall !== 1'b0) $display("[TB] FAIL stall_release: got %b want 0", stall); else passed++;
    memwb_regwrite = 1; memwb_rd = 5'd6; memwb_result = 32'd77;
    step();
    memwb_regwrite = 0; #1;
    total++; if (ex_valid !== 1'b1) $display("[TB] FAIL add_valid: got %b want 1", ex_valid); else passed++;
    total++; if (ex_rd !== 5'd7) $display("[TB] FAIL add_rd: got %0d want 7", ex_rd); else passed++;
    total++; if (ALUop1 !== 32'd10) $display("[TB] FAIL add_op1: got %0d want 10", ALUop1); else passed++;
    total++; if (ALUop2 !== 32'd77) $display("[TB] FAIL add_op2_bypass: got %0d want 77", ALUop2); else passed++;
    idle_inputs();
  endtask

  task automatic test_flush_hazard();
    load_lw_x6();
    id_valid = 1; id_rs1 = 5'd6; id_rd = 5'd9; id_aluctrl = 4'h5; id_regwrite = 1;
    flush = 1;
    #1;
    total++; if (stall !== 1'b0) $display("[TB] FAIL flush_stall: got %b want 0", stall); else passed++;
    step();
    total++; if (ex_valid !== 1'b0) $display("[TB] FAIL flush_valid: got %b want 0", ex_valid); else passed++;
    total++; if (ex_rd !== 5'd0) $display("[TB] FAIL flush_rd: got %0d want 0", ex_rd); else passed++;
    total++; if (ALUctrl !== 8'h00) $display("[TB] FAIL flush_aluctrl: got %h want 00", ALUctrl); else passed++;
    flush = 0; id_valid = 0;
    step();
    total++; if (ex_regwrite !== 1'b0) $display("[TB] FAIL flushed_never_writes: got %b want 0", ex_regwrite); else passed++;
    idle_inputs();
  endtask

  task automatic test_capture_bypass();
    idle_inputs();
    memwb_regwrite = 1; memwb_rd = 5'd3; memwb_result = 32'h1234;
    id_valid = 1; id_rs1 = 5'd3; id_rd1 = 32'd0; id_rs2 = 5'd3; id_rd2 = 32'd0;
    step();
    memwb_regwrite = 0; id_valid = 0; #1;
    total++; if (ALUop1 !== 32'h1234) $display("[TB] FAIL cap_bypass_op1: got %h want 1234", ALUop1); else passed++;
    total++; if (ex_store_data !== 32'h1234) $display("[TB] FAIL cap_bypass_rs2: got %h want 1234", ex_store_data); else passed++;
    idle_inputs();
    memwb_regwrite = 1; memwb_rd = 5'd0; memwb_result = 32'h5555;
    id_valid = 1; id_rs1 = 5'd0; id_rd1 = 32'd0;
    step();
    memwb_regwrite = 0; #1;
    total++; if (ALUop1 !== 32'd0) $display("[TB] FAIL cap_bypass_x0: got %h want 0", ALUop1); else passed++;
    idle_inputs();
  endtask

  task automatic test_valid_gating();
    idle_inputs();
    id_valid = 0; id_rd = 5'd4; id_regwrite = 1; id_memread = 1;
    step();
    total++; if (ex_regwrite !== 1'b0) $display("[TB] FAIL gated_regwrite: got %b want 0", ex_regwrite); else passed++;
    total++; if (ex_memread !== 1'b0) $display("[TB] FAIL gated_memread: got %b want 0", ex_memread); else passed++;
    idle_inputs();
    id_valid = 1; id_rs1 = 5'd4; #1;
    total++; if (stall !== 1'b0) $display("[TB] FAIL invalid_load_no_stall: got %b want 0", stall); else passed++;
    idle_inputs();
  endtask

  task automatic test_reset_mid_stall();
    load_lw_x6();
    id_valid = 1; id_rs1 = 5'd6; id_rd = 5'd2;
    #1;
    total++; if (stall !== 1'b1) $display("[TB] FAIL pre_reset_stall: got %b want 1", stall); else passed++;
    rst_n = 0;
    step();
    rst_n = 1; #1;
    total++; if (ex_valid !== 1'b0) $display("[TB] FAIL reset_bubble_valid: got %b want 0", ex_valid); else passed++;
    total++; if (stall !== 1'b0) $display("[TB] FAIL reset_drops_stall: got %b want 0", stall); else passed++;
    idle_inputs();
  endtask

`ifdef EX_PERF_CNT_EN
  task automatic test_perf_cnt();
    idle_inputs();
    rst_n = 0; step(); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      load_lw_x6();
      id_valid = 1; id_rs2 = 5'd6;
      step();
      idle_inputs();
    end
    flush = 1; step(); step(); flush = 0;
    total++; if (stall_cnt !== 32'd3) $display("[TB] FAIL stall_cnt: got %0d want 3", stall_cnt); else passed++;
    total++; if (flush_cnt !== 32'd2) $display("[TB] FAIL flush_cnt: got %0d want 2", flush_cnt); else passed++;
    load_lw_x6();
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    id_valid = 1; id_rs1 = 5'd6;
    step();
    total++; if (stall_cnt !== 32'hFFFF_FFFF) $display("[TB] FAIL stall_cnt_sat: got %h want ffffffff", stall_cnt); else passed++;
    idle_inputs();
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_exmem_fwd();
    test_load_use();
    test_flush_hazard();
    test_capture_bypass();
    test_valid_gating();
    test_reset_mid_stall();
`ifdef EX_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
